// File: rtl/vect_mem_pkg.sv
// Shared constants, FSM state encoding and lane address arithmetic for the
// vector memory controller.
package vect_mem_pkg;

  localparam int DEF_LANES    = 16;
  localparam int DEF_ELEM_W   = 16;
  localparam int DEF_DEPTH    = 1024;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_STRIDE_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef logic [DEF_ELEM_W-1:0] elem_t;

  // base + idx*stride with natural wrap; stride_x is already sign-extended.
  // The low ADDR_W bits of the result are exact for any ADDR_W up to 32.
  function automatic logic [DEF_ADDR_W-1:0] lane_addr(
    input logic [DEF_ADDR_W-1:0] base,
    input logic [DEF_ADDR_W-1:0] stride_x,
    input logic [DEF_ADDR_W-1:0] idx
  );
    return base + idx * stride_x;
  endfunction

endpackage

// File: rtl/vect_mem_bank.sv
// Single-port element-wide synchronous RAM with one-cycle read latency.
// The array is deliberately not reset so contents survive a controller reset.
module vect_mem_bank #(
  parameter int ELEM_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [ELEM_W-1:0] wdata,
  output logic [ELEM_W-1:0] rdata
);

  logic [ELEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/vect_mem_ctrl.sv
// Vector load/store controller: serialises one strided, masked vector request
// into per-lane element accesses and returns the whole vector as one response.
module vect_mem_ctrl
  import vect_mem_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int ELEM_W   = DEF_ELEM_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int STRIDE_W = DEF_STRIDE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [STRIDE_W-1:0]       req_stride,
  input  logic [LANES-1:0]          req_mask,
  input  logic [LANES*ELEM_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [LANES*ELEM_W-1:0]   resp_rdata,
  output logic                      resp_err,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t                    state;
  logic [LW-1:0]             lane;
  logic                      cap_we;
  logic [ADDR_W-1:0]         cap_addr;
  logic [STRIDE_W-1:0]       cap_stride;
  logic [LANES-1:0]          cap_mask;
  logic [LANES*ELEM_W-1:0]   cap_wdata;
  logic [LANES*ELEM_W-1:0]   rdata;
  logic                      err;
  logic                      rd_pend;
  logic [LW-1:0]             rd_lane;

  logic [ADDR_W-1:0]         stride_x;
  logic [ADDR_W-1:0]         lane_address;
  logic                      lane_in_range;
  logic                      lane_en;
  logic                      bank_en;
  logic                      bank_we;
  logic [ELEM_W-1:0]         bank_wdata;
  logic [ELEM_W-1:0]         bank_rdata;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. req_ready is high only in IDLE; resp_valid is high only in RESP,
  // and resp_rdata/resp_err stay frozen until resp_ready completes the transfer.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_rdata = rdata;
  assign resp_err   = err;
  assign dbg_state  = state;

  assign stride_x      = {{(ADDR_W-STRIDE_W){cap_stride[STRIDE_W-1]}}, cap_stride};
  assign lane_address  = ADDR_W'(lane_addr(DEF_ADDR_W'(cap_addr), DEF_ADDR_W'(stride_x),
                                           DEF_ADDR_W'(lane)));
  assign lane_in_range = (lane_address < ADDR_W'(DEPTH));
  assign lane_en       = cap_mask[lane];

  // Bank strobes are decoded from live state so an async reset kills them at once.
  assign bank_en    = (state == ACCESS) && lane_en && lane_in_range;
  assign bank_we    = bank_en && cap_we;
  assign bank_wdata = cap_wdata[32'(lane)*ELEM_W +: ELEM_W];

  vect_mem_bank #(
    .ELEM_W (ELEM_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (bank_we),
    .addr  (lane_address[AW-1:0]),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane       <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_stride <= '0;
      cap_mask   <= '0;
      cap_wdata  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      rd_pend    <= 1'b0;
      rd_lane    <= '0;
    end else begin
      rd_pend <= 1'b0;
      // Read data lands one edge after issue, which may be the DRAIN edge.
      if (rd_pend) begin
        rdata[32'(rd_lane)*ELEM_W +: ELEM_W] <= bank_rdata;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_stride <= req_stride;
            cap_mask   <= req_mask;
            cap_wdata  <= req_wdata;
            rdata      <= '0;
            err        <= 1'b0;
            lane       <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (lane_en && !lane_in_range) begin
            err <= 1'b1;
          end
          if (bank_en && !cap_we) begin
            rd_pend <= 1'b1;
            rd_lane <= lane;
          end
          if (lane == LAST_LANE) begin
            state <= DRAIN;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        DRAIN: begin
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vect_mem_ctrl.sv
// Scenario bench for vect_mem_ctrl: each task drives one feature and checks the
// response against an expected queue filled when the request is sent.
module tb_vect_mem_ctrl;

  localparam int LANES  = 16;
  localparam int ELEM_W = 16;
  localparam int W      = LANES * ELEM_W;

  logic           clk;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [31:0]    req_addr;
  logic [15:0]    req_stride;
  logic [15:0]    req_mask;
  logic [W-1:0]   req_wdata;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_rdata;
  logic           resp_err;
  logic           busy;
  logic [1:0]     dbg_state;

  logic [W-1:0]   exp_q[$];
  logic           exp_err_q[$];
  int             total;
  int             bad;

  vect_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_stride (req_stride),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // lane i = base + i where mask bit i is set, else 0
  function automatic logic [W-1:0] seq_vec(input logic [15:0] base, input logic [15:0] mask);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) v[i*ELEM_W +: ELEM_W] = base + 16'(i);
    end
    return v;
  endfunction

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [15:0] stride,
                          input logic [15:0] mask, input logic [W-1:0] wdata,
                          input logic [W-1:0] exp_rdata, input logic exp_err,
                          input int hold, input string name);
    int edges;
    logic [W-1:0] held;
    logic [W-1:0] exp_d;
    logic exp_e;
    exp_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_stride = stride;
    req_mask   = mask;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
      if (resp_valid === 1'b1) break;
    end
    total++;
    if (edges != LANES + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d edges want %0d", name, edges, LANES + 1);
    end
    held = resp_rdata;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s stall cycle %0d: valid=%b ready=%b rdata=%h want valid=1 ready=0 rdata=%h",
                 name, c, resp_valid, req_ready, resp_rdata, held);
      end
    end
    exp_d = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    total++;
    if (resp_rdata !== exp_d) begin
      bad++;
      $display("FAIL %s rdata: got %h want %h", name, resp_rdata, exp_d);
    end
    total++;
    if (resp_err !== exp_e) begin
      bad++;
      $display("FAIL %s err: got %b want %b", name, resp_err, exp_e);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release: valid=%b ready=%b busy=%b want 0 1 0",
               name, resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0 ||
        busy !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset outputs: ready=%b valid=%b rdata=%h err=%b busy=%b state=%0d",
               req_ready, resp_valid, resp_rdata, resp_err, busy, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_contiguous;
    send_req(1'b1, 32'd0, 16'd1, 16'hFFFF, seq_vec(16'h0100, 16'hFFFF), '0, 1'b0, 0, "store0");
    send_req(1'b0, 32'd0, 16'd1, 16'hFFFF, '0, seq_vec(16'h0100, 16'hFFFF), 1'b0, 0, "load0");
  endtask

  task automatic test_strided;
    logic [W-1:0] e;
    send_req(1'b1, 32'd16, 16'd1, 16'hFFFF, seq_vec(16'h0200, 16'hFFFF), '0, 1'b0, 0, "store16");
    e = '0;
    for (int i = 0; i < 8; i++) e[i*ELEM_W +: ELEM_W] = 16'h0100 + 16'(2 * i);
    send_req(1'b0, 32'd0, 16'd2, 16'h00FF, '0, e, 1'b0, 0, "stride2");
  endtask

  task automatic test_reverse;
    logic [W-1:0] e;
    for (int i = 0; i < LANES; i++) e[i*ELEM_W +: ELEM_W] = 16'h0100 + 16'(15 - i);
    send_req(1'b0, 32'd15, 16'hFFFF, 16'hFFFF, '0, e, 1'b0, 0, "reverse");
  endtask

  task automatic test_range;
    logic [W-1:0] e;
    send_req(1'b1, 32'd1008, 16'd1, 16'hFFFF, seq_vec(16'h0300, 16'hFFFF), '0, 1'b0, 0, "store1008");
    e = '0;
    for (int i = 0; i < 4; i++) e[i*ELEM_W +: ELEM_W] = 16'h030C + 16'(i);
    send_req(1'b0, 32'd1020, 16'd1, 16'hFFFF, '0, e, 1'b1, 0, "load_oor");
    send_req(1'b1, 32'd1020, 16'd1, 16'hFFFF, seq_vec(16'hEE00, 16'hFFFF), '0, 1'b1, 0, "store_oor");
    send_req(1'b0, 32'd0, 16'd1, 16'hFFFF, '0, seq_vec(16'h0100, 16'hFFFF), 1'b0, 0, "no_wrap");
    e = '0;
    for (int i = 0; i < 4; i++) e[i*ELEM_W +: ELEM_W] = 16'hEE00 + 16'(i);
    send_req(1'b0, 32'd1020, 16'd1, 16'h000F, '0, e, 1'b0, 0, "oor_written");
  endtask

  task automatic test_same_addr;
    logic [W-1:0] e;
    send_req(1'b1, 32'd5, 16'd0, 16'hFFFF, seq_vec(16'h0000, 16'hFFFF), '0, 1'b0, 0, "stride0");
    e = '0;
    e[ELEM_W-1:0] = 16'd15;
    send_req(1'b0, 32'd5, 16'd1, 16'h0001, '0, e, 1'b0, 0, "last_wins");
    send_req(1'b0, 32'd5, 16'd1, 16'h0000, '0, '0, 1'b0, 0, "mask0");
  endtask

  task automatic test_stall;
    logic [W-1:0] e;
    e = seq_vec(16'h0100, 16'hFFFF);
    e[5*ELEM_W +: ELEM_W] = 16'd15;
    send_req(1'b0, 32'd0, 16'd1, 16'hFFFF, '0, e, 1'b0, 10, "stall");
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'd0;
    req_stride = 16'd1;
    req_mask   = 16'hFFFF;
    req_wdata  = seq_vec(16'hA000, 16'hFFFF);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy: busy=%b ready=%b want 1 0", busy, req_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ready=%b valid=%b rdata=%h err=%b busy=%b",
               req_ready, resp_valid, resp_rdata, resp_err, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = seq_vec(16'h0100, 16'hFFFF);
    for (int i = 0; i < 7; i++) e[i*ELEM_W +: ELEM_W] = 16'hA000 + 16'(i);
    send_req(1'b0, 32'd0, 16'd1, 16'hFFFF, '0, e, 1'b0, 0, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] img;
    logic [W-1:0] e;
    logic [15:0]  m;
    img = seq_vec(16'h0100, 16'hFFFF);
    for (int i = 0; i < 7; i++) img[i*ELEM_W +: ELEM_W] = 16'hA000 + 16'(i);
    for (int k = 0; k < 4; k++) begin
      m = 16'($urandom_range(0, 16'hFFFF));
      e = '0;
      for (int i = 0; i < LANES; i++) begin
        if (m[i]) e[i*ELEM_W +: ELEM_W] = img[i*ELEM_W +: ELEM_W];
      end
      send_req(1'b0, 32'd0, 16'd1, m, '0, e, 1'b0, 0, "b2b_mask");
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_stride = '0;
    req_mask   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    test_reset();
    test_contiguous();
    test_strided();
    test_reverse();
    test_range();
    test_same_addr();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vect_mem_ctrl.md
Name: vect_mem_ctrl

Overview:
- Parametrised successor to the vectmanager vector memory.
- Accepts one vector load/store request per transaction with base address, signed element stride and per-lane mask.
- Serialises the request into one element access per cycle against an internal element-wide synchronous RAM, then returns the full vector through a valid/ready response.
- Sits between the vector register file / execute stage and data storage; addresses are in element units, so a base of 16 selects the next contiguous 16-lane vector.

Parameters:
- LANES, 16: elements per vector.
- ELEM_W, 16: bits per element.
- DEPTH, 1024: elements of storage.
- ADDR_W, 32: request address width.
- STRIDE_W, 16: signed stride width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  element address of lane 0.
- req_stride  in  STRIDE_W  signed element stride between lanes.
- req_mask  in  LANES  lane enable; bit i is lane i.
- req_wdata  in  LANES*ELEM_W  store data; lane i = bits [i*ELEM_W +: ELEM_W].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  LANES*ELEM_W  load data; same lane packing as req_wdata.
- resp_err  out  1  at least one enabled lane was out of range.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Lane counter and captured request are cleared.
  - RAM contents are not cleared.
- FSM states: IDLE, ACCESS, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at an edge, capture we/addr/stride/mask/wdata, clear rdata and err, set lane=0, go to ACCESS.
- ACCESS: lane i is processed on each edge, i = 0..LANES-1, one per cycle whether masked or not.
  - Lane address = req_addr + i*sext(req_stride), computed modulo 2^ADDR_W.
  - In range means lane address < DEPTH.
  - Store, enabled, in range: write wdata lane i to RAM.
  - Load, enabled, in range: issue a RAM read. Data returns on the next edge and is written into rdata lane i.
  - Disabled lane: no RAM access; rdata lane stays 0 (zeroing, not merge).
  - Enabled lane out of range: no access, rdata lane 0, err set (sticky for this request).
  - After lane LANES-1, go to DRAIN.
- DRAIN: one cycle to capture the final read lane, then go to RESP.
- RESP:
  - resp_valid=1; rdata and err held stable.
  - On resp_ready, return to IDLE; resp_valid drops the cycle after the handshake.
  - Store responses return rdata=0; err has the same meaning as for loads.
- Latency: resp_valid is visible after edge LANES+1 counted from the accept edge (17 for LANES=16). Loads and stores have identical latency.
- No new request is accepted until the response is consumed; req_ready=0 throughout ACCESS/DRAIN/RESP.
- Same address hit by several lanes of one store (e.g. stride 0): the highest-numbered enabled lane wins.
- A load issued after a completed store sees the stored data.
- Reset mid-operation: the request is aborted immediately. Stores from lanes already processed persist; later lanes are not written; no response is produced.
- resp_valid without resp_ready may be held indefinitely; outputs must not change meanwhile.

Decomposition:
- Package vect_mem_pkg holds:
  - default LANES/ELEM_W/DEPTH constants;
  - state_t enum {IDLE, ACCESS, DRAIN, RESP};
  - elem_t typedef (logic [ELEM_W-1:0]);
  - lane address helper function (base + i*stride, wrap).
- Sub-module vect_mem_bank:
  - single-port synchronous RAM, ELEM_W x DEPTH;
  - we/addr/wdata/rdata;
  - 1-cycle read latency;
  - no reset on the array.

Test Plan:
1. Store addr 0, stride 1, mask FFFF, lane i = 16'h0100+i; then load the same → rdata lane i = 16'h0100+i, resp_err=0, resp_valid 17 edges after each accept.
2. After test 1 plus a store at addr 16 with lane i = 16'h0200+i: load addr 0, stride 2, mask 00FF → lanes 0-7 = 0100,0102,...,010E; lanes 8-15 = 0.
3. Load addr 15, stride -1 (16'hFFFF), mask FFFF → lane i = 16'h0100+(15-i), i.e. a reversed vector.
4. Load addr 1020, stride 1, mask FFFF (DEPTH=1024) → lanes 0-3 = RAM[1020..1023], lanes 4-15 = 0, resp_err=1. A store with the same parameters leaves RAM[0..11] unchanged.
5. Store addr 5, stride 0, mask FFFF, lane i = i, then load addr 5 stride 1 mask 0001 → lane 0 = 15; load addr 5 mask 0000 → all 0, resp_err=0.
6. Hold resp_ready=0 for 10 cycles → resp_valid/rdata stable, req_ready=0. Then: store a contiguous vector with lane i = 16'hA000+i; assert rst_n=0 while lane 7 is being processed → outputs at reset values without waiting for a clock edge. After reset release, req_ready=1; reloading shows lanes 0-6 = A000..A006 and lanes 7-15 unchanged from before.
